stream_mux_nb_rr: RTL and testbench

Parametrised N-channel, NBITS-wide stream multiplexer, the sequential successor to the fixed 4-bit 8-to-1 combinational mux. Each input is a val/rdy stream. The block picks one input per cycle, either by an external select or by a round-robin arbiter, and captures the winner into a single registered output stage with val/rdy handshake. It sits between several producer streams and one shared consumer.

---
 rtl/stream_mux_nb_rr.sv | 132 +++++++++++++
 tb/tb_stream_mux_nb_rr.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_nb_rr.sv
// N-channel val/rdy stream multiplexer with select-directed or round-robin
// arbitration feeding a single registered output stage.
module stream_mux_nb_rr #(
    parameter int NBITS = 4,
    parameter int NCHAN = 8,
    parameter int SELW  = $clog2(NCHAN)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NCHAN*NBITS-1:0] in_data,
    input  logic [NCHAN-1:0]       in_val,
    output logic [NCHAN-1:0]       in_rdy,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [NBITS-1:0]       out_data,
    output logic [SELW-1:0]        out_chan,
    output logic                   out_val,
    input  logic                   out_rdy
);

    logic [NBITS-1:0] out_data_r;
    logic [SELW-1:0]  out_chan_r;
    logic             out_val_r;
    logic [SELW-1:0]  rr_ptr_r;

    logic             stage_free_s;
    logic             sel_hit_s;
    logic             rr_hit_s;
    logic [SELW-1:0]  rr_idx_s;
    logic             grant_s;
    logic [SELW-1:0]  gidx_s;
    logic [NBITS-1:0] win_data_s;
    logic [NCHAN-1:0] in_rdy_s;
    logic             accept_s;

    // (base + off) modulo NCHAN; base and off are both below NCHAN.
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                                 input int unsigned     off);
        logic [SELW:0] sum;
        sum = {1'b0, base} + (SELW+1)'(off);
        if (sum >= (SELW+1)'(NCHAN)) begin
            sum = sum - (SELW+1)'(NCHAN);
        end else begin
            sum = sum;
        end
        return sum[SELW-1:0];
    endfunction

    // Stage can take a new word when it is empty or being drained this cycle.
    always_comb begin
        stage_free_s = ~out_val_r | out_rdy;
    end

    // Select-directed hit; a select beyond NCHAN-1 matches no channel.
    always_comb begin
        sel_hit_s = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            sel_hit_s = sel_hit_s | ((sel == SELW'(i)) & in_val[i]);
        end
    end

    // Round-robin search: scan offsets high to low so the nearest valid
    // channel at or after rr_ptr is the last one written.
    always_comb begin
        rr_hit_s = 1'b0;
        rr_idx_s = rr_ptr_r;
        for (int off = NCHAN - 1; off >= 0; off--) begin
            rr_hit_s = rr_hit_s | in_val[wrap_add(rr_ptr_r, off)];
            rr_idx_s = in_val[wrap_add(rr_ptr_r, off)] ? wrap_add(rr_ptr_r, off) : rr_idx_s;
        end
    end

    // Final grant selection between the two arbitration modes.
    always_comb begin
        grant_s = mode ? rr_hit_s : sel_hit_s;
        gidx_s  = mode ? rr_idx_s : sel;
    end

    // Winning channel data (AND-OR mux keeps in_data off every output path).
    always_comb begin
        win_data_s = {NBITS{1'b0}};
        for (int i = 0; i < NCHAN; i++) begin
            win_data_s = win_data_s
                       | ({NBITS{gidx_s == SELW'(i)}} & in_data[i*NBITS +: NBITS]);
        end
    end

    // One-hot ready toward the granted producer, forced low during reset.
    always_comb begin
        accept_s = reset_n & grant_s & stage_free_s;
        in_rdy_s = {NCHAN{1'b0}};
        for (int i = 0; i < NCHAN; i++) begin
            in_rdy_s[i] = accept_s & (gidx_s == SELW'(i));
        end
    end

    assign in_rdy   = in_rdy_s;
    assign out_data = out_data_r;
    assign out_chan = out_chan_r;
    assign out_val  = out_val_r;

    // Output stage: capture on accept, empty when free with nothing granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_r <= {NBITS{1'b0}};
            out_chan_r <= {SELW{1'b0}};
            out_val_r  <= 1'b0;
        end else if (stage_free_s) begin
            if (grant_s) begin
                out_data_r <= win_data_s;
                out_chan_r <= gidx_s;
                out_val_r  <= 1'b1;
            end else begin
                out_val_r  <= 1'b0;
            end
        end else begin
            out_val_r  <= out_val_r;
        end
    end

    // Round-robin pointer advances past the winner only on round-robin accepts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= {SELW{1'b0}};
        end else if (accept_s && mode) begin
            rr_ptr_r <= (gidx_s == SELW'(NCHAN - 1)) ? {SELW{1'b0}} : gidx_s + SELW'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: tb/tb_stream_mux_nb_rr.sv
// Self-checking bench for stream_mux_nb_rr: directed scenarios followed by
// random traffic, compared against a cycle-level behavioural model.
module tb_stream_mux_nb_rr;

    localparam int NBITS = 4;
    localparam int NCHAN = 8;
    localparam int SELW  = 3;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NCHAN*NBITS-1:0] in_data;
    logic [NCHAN-1:0]       in_val;
    logic [NCHAN-1:0]       in_rdy;
    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NBITS-1:0]       out_data;
    logic [SELW-1:0]        out_chan;
    logic                   out_val;
    logic                   out_rdy;

    logic [NBITS-1:0] din [NCHAN];

    // model state
    int               m_rr;
    logic             m_val;
    logic [NBITS-1:0] m_data;
    int               m_chan;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NCHAN; i++) in_data[i*NBITS +: NBITS] = din[i];
    end

    stream_mux_nb_rr #(.NBITS(NBITS), .NCHAN(NCHAN)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_val(in_val),
        .in_rdy(in_rdy), .mode(mode), .sel(sel), .out_data(out_data),
        .out_chan(out_chan), .out_val(out_val), .out_rdy(out_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant(input logic m, input int s, input logic [NCHAN-1:0] v, input int rr);
        if (!m) return (s < NCHAN && v[s]) ? s : -1;
        for (int k = 0; k < NCHAN; k++) begin
            if (v[(rr + k) % NCHAN]) return (rr + k) % NCHAN;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_val = 1'b0; m_data = '0; m_chan = 0;
    endtask

    // One clock: inputs already applied at a falling edge.
    task automatic cycle();
        int g;
        bit free;
        logic [NCHAN-1:0] erdy;
        #1;
        g    = exp_grant(mode, int'(sel), in_val, m_rr);
        free = !m_val || out_rdy;
        erdy = (g >= 0 && free) ? (NCHAN'(1) << g) : '0;
        chk("in_rdy", 32'(in_rdy), 32'(erdy));
        @(posedge clk);
        if (free) begin
            if (g >= 0) begin
                m_val = 1'b1; m_data = din[g]; m_chan = g;
                if (mode) m_rr = (g + 1) % NCHAN;
            end else begin
                m_val = 1'b0;
            end
        end
        @(negedge clk);
        chk("out_val", 32'(out_val), 32'(m_val));
        if (m_val) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_chan", 32'(out_chan), 32'(m_chan));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0; mode = 1'b1; sel = '0; out_rdy = 1'b1; in_val = 8'hFF;
        for (int i = 0; i < NCHAN; i++) din[i] = NBITS'(i + 8);
        model_reset();

        // reset state with every channel requesting
        repeat (2) @(negedge clk);
        chk("rst_in_rdy", 32'(in_rdy), 32'h0);
        chk("rst_out_val", 32'(out_val), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_chan", 32'(out_chan), 32'h0);
        reset_n = 1'b1;
        cycle();
        chk("first_grant", 32'(out_chan), 32'h0);

        // select-directed sweep
        mode = 1'b0;
        for (int s = 0; s < NCHAN; s++) begin
            sel = SELW'(s);
            cycle();
            chk("sel_data", 32'(out_data), 32'(s + 8));
            chk("sel_chan", 32'(out_chan), 32'(s));
        end

        // select on an idle channel
        sel = 3'd5; in_val = 8'b1101_1111;
        cycle();
        chk("idle_rdy", 32'(in_rdy), 32'h0);
        chk("idle_val", 32'(out_val), 32'h0);

        // round-robin fairness
        do_reset();
        mode = 1'b1; in_val = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("rr_seq", 32'(out_chan), 32'(k % 8));
        end
        in_val = 8'b1000_0100;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_alt", 32'(out_chan), (k % 2 == 1) ? 32'd7 : 32'd2);
        end

        // backpressure
        mode = 1'b0; sel = 3'd2; din[2] = 4'hA; in_val = 8'hFF; out_rdy = 1'b1;
        cycle();
        chk("bp_load", 32'(out_data), 32'hA);
        din[2] = 4'h3; out_rdy = 1'b0;
        repeat (3) begin
            cycle();
            chk("bp_rdy", 32'(in_rdy), 32'h0);
            chk("bp_hold", 32'(out_data), 32'hA);
            chk("bp_val", 32'(out_val), 32'h1);
        end
        out_rdy = 1'b1;
        cycle();
        chk("bp_next", 32'(out_data), 32'h3);

        // reset mid-stream with rr_ptr at 5
        do_reset();
        mode = 1'b1; in_val = 8'hFF;
        repeat (5) cycle();
        chk("mid_pre", 32'(out_chan), 32'd4);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_val", 32'(out_val), 32'h0);
        chk("mid_data", 32'(out_data), 32'h0);
        chk("mid_chan", 32'(out_chan), 32'h0);
        chk("mid_rdy", 32'(in_rdy), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1; in_val = 8'b0011_0000;
        cycle();
        chk("mid_first", 32'(out_chan), 32'd4);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            in_val  = ($urandom_range(0, 7) == 0) ? '0 : NCHAN'($urandom);
            mode    = 1'($urandom);
            sel     = SELW'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NCHAN; i++) din[i] = NBITS'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
